sw_seq_feeder: RTL
==================

# sw_seq_feeder

Front-end stage for the Smith-Waterman systolic array. It buffers one query (S) and one database sequence (T) from a host stream, then drives the array:
- preloads S into the PEs through the save-S token;
- streams T and flushes the pipeline;
- samples the final local-alignment score from the array's `max_out`.

It also pulses the array reset between jobs, because the array's save-S logic is one-shot per reset.

## Interface
- `PE_NUMBER`, 128, PE count; query length is exactly this.
- `T_MAX`, 1024, maximum T length in symbols.
- `ARR_LAT`, 1, extra cycles from T symbol entry at PE0 to its effect on the last PE's `max_out`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: host symbol valid.
- `in_ready` out 1: feeder accepts a symbol.
- `in_is_t` in 1: 0 = S symbol, 1 = T symbol.
- `in_last` in 1: final symbol of the current sequence.
- `in_base` in 2: nucleotide code.
- `arr_reset` out 1: reset to `pe_array`.
- `arr_valid` out 1: `pe_array` `valid`.
- `pe_enable` out 1: `pe_array` `pe_enable`.
- `s_out` out 2: `pe_array` `s_in`.
- `t_out` out 2: `pe_array` `t_in`.
- `max_in`, `v_in`, `f_in` out 12 each: boundary values; constant 0.
- `arr_max` in 12: `pe_array` `max_out`.
- `done` out 1: one-cycle pulse when the score is valid.
- `score` out 12: last job's score; held until the next `done`.
- `err` out 1: sticky protocol error; cleared only by `reset`.

## Operation
- States: IDLE, LOAD_S, LOAD_T, ARST, SEED, STREAM, FLUSH, DONE.
- **Handshake.** A beat is accepted on `in_valid && in_ready`. `in_ready` = 1 in IDLE, LOAD_S and LOAD_T only.
- **IDLE.** The first accepted beat must have `in_is_t` = 0. It is written to S[0] and the FSM goes to LOAD_S.
- **LOAD_S.** Writes S[s_cnt].
  - `in_last` with s_cnt == PE_NUMBER-1 → LOAD_T.
  - Any other length, or `in_is_t` = 1, sets `err` and returns to IDLE; buffers are discarded.
- **LOAD_T.** Writes T[t_cnt].
  - `in_last` → ARST, latching `t_len` = t_cnt+1.
  - Beat `T_MAX`+1, or an `in_is_t` = 0 beat, sets `err` → IDLE.
- **ARST.** `arr_reset` = 1 for exactly 1 cycle → SEED.
- **SEED.** PE_NUMBER cycles.
  - `arr_valid` = 1.
  - `s_out` = S[k] in SEED cycle k (k = 0..PE_NUMBER-1).
  - `pe_enable` = 0.
  - → STREAM.
- **STREAM.** `t_len` cycles.
  - `pe_enable` = 1.
  - `t_out` = T[j] in STREAM cycle j.
  - `arr_valid` stays 1.
- **FLUSH.** PE_NUMBER-1+ARR_LAT cycles.
  - `pe_enable` = 1, `t_out` = 0.
  - On the last FLUSH cycle, `score` <= `arr_max`.
  - → DONE.
- **DONE.** `done` = 1 for 1 cycle, `arr_valid` = 0 → IDLE.
- **Arithmetic.** The feeder does no score arithmetic. `score` is `arr_max` sampled unmodified.
- **Counters.**
  - s_cnt: $clog2(PE_NUMBER) bits.
  - t_cnt / `t_len`: $clog2(T_MAX+1) bits.
  - Phase counter: wide enough for max(T_MAX, PE_NUMBER+ARR_LAT).
- **Single-symbol T** (`t_len` = 1) is legal: STREAM lasts 1 cycle.

## Timing
- **Reset values:**
  - `in_ready` = 0 during reset, then 1 in IDLE.
  - `arr_reset` = 1 while `reset` is high; it follows `reset` combinationally OR the ARST state.
  - `arr_valid`, `pe_enable`, `done`, `err` = 0.
  - `s_out`, `t_out`, `max_in`, `v_in`, `f_in`, `score` = 0.
- **Reset mid-job:** returns to IDLE next cycle. `score` is cleared, `done` is not raised, buffer contents are don't-care.
- All array-facing outputs are registered and change only on rising `clk`. The array samples `valid` on falling edge, so `arr_valid` must be stable by then.
- **Latency:**
  - Last host beat → first SEED cycle: 2 cycles.
  - First SEED cycle → `done`: PE_NUMBER + `t_len` + PE_NUMBER-1+ARR_LAT + 1 cycles.
- **Throughput:** host input is back-pressured (`in_ready` = 0) from ARST through DONE. The next job may start the cycle after DONE.
- **Buffer reads:** 1-cycle synchronous read. The read address is pre-issued one cycle before each SEED/STREAM symbol so `s_out`/`t_out` align exactly with the state cycle.

## Structure
- Package `sw_pkg`:
  - `SYM_W` = 2, `SCORE_W` = 12.
  - Base codes A=0, C=1, G=2, T=3.
  - FSM state enum.
- Sub-module `sym_buffer`: parameterised depth, 2-bit wide, one write port, one synchronous read port. Instantiated twice, for S (depth PE_NUMBER) and T (depth T_MAX).

## Test plan
- **Exact match.** PE_NUMBER=4, S=ACGT, T=ACGT → `done` after 4+4+4+1 cycles; `score` equals the array golden model (match score ×4); one `arr_reset` pulse observed.
- **No match.** S=AAAA, T=CCCCCC → `score` = 0; `s_out` sequence 0,0,0,0 in SEED; `t_out` 1×6 then 0×(3+ARR_LAT).
- **Short S.** `in_last` on the 3rd S beat with PE_NUMBER=4 → `err` = 1, returns to IDLE, no `arr_valid`.
- **T overflow.** T_MAX=8, send 9 T beats → `err` = 1 on the 9th beat, `in_ready` still 1 in IDLE.
- **Back-to-back jobs with random `in_valid` gaps.** Second `done` reports an independent score; a second `arr_reset` precedes the second SEED; `in_ready` = 0 throughout ARST..DONE.
- **Reset asserted mid-STREAM.** Next cycle `pe_enable` = 0, `arr_valid` = 0, `score` = 0, no `done`; a following full job completes correctly.

Source files
------------

// File: rtl/sw_pkg.sv
// sw_pkg: shared widths, nucleotide codes and the feeder FSM state type
// for the Smith-Waterman front-end.
package sw_pkg;

    localparam int SYM_W   = 2;
    localparam int SCORE_W = 12;

    localparam logic [SYM_W-1:0] BASE_A = 2'd0;
    localparam logic [SYM_W-1:0] BASE_C = 2'd1;
    localparam logic [SYM_W-1:0] BASE_G = 2'd2;
    localparam logic [SYM_W-1:0] BASE_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_S,
        ST_LOAD_T,
        ST_ARST,
        ST_SEED,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sym_buffer.sv
// sym_buffer: simple dual-port symbol store (one write port, one registered
// read port), sized to map onto block RAM.
// Ports:
//   clk, srst        clock and synchronous active-high reset (read register only)
//   i_wr_en/addr/data write port
//   i_rd_en/addr     read request; data appears on o_rd_data the next cycle
//   o_rd_data        registered read data; reads as 0 on cycles with no request
// DEPTH is expected to be a power of two so every address is in range.
module sym_buffer
    import sw_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [SYM_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [SYM_W-1:0] o_rd_data
);

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [SYM_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register doubles as the array-facing symbol register: it is
    // cleared when no read is requested so the array sees 0 outside the phase.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sw_seq_feeder.sv
// sw_seq_feeder: buffers one query S and one database sequence T from the
// host stream, then drives the systolic array: array reset pulse, S seeding,
// T streaming, pipeline flush, and final score capture from max_out.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          host handshake; in_is_t selects S/T, in_last ends a sequence
//   in_base                    nucleotide code
//   arr_reset, arr_valid,
//   pe_enable, s_out, t_out    registered array controls and symbols
//   max_in, v_in, f_in         array boundary values (tied to 0)
//   arr_max                    array max_out
//   done, score, err           job-complete pulse, held score, sticky protocol error
module sw_seq_feeder
    import sw_pkg::*;
#(
    parameter int PE_NUMBER = 128,
    parameter int T_MAX     = 1024,
    parameter int ARR_LAT   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_t,
    input  logic               in_last,
    input  logic [SYM_W-1:0]   in_base,
    output logic               arr_reset,
    output logic               arr_valid,
    output logic               pe_enable,
    output logic [SYM_W-1:0]   s_out,
    output logic [SYM_W-1:0]   t_out,
    output logic [SCORE_W-1:0] max_in,
    output logic [SCORE_W-1:0] v_in,
    output logic [SCORE_W-1:0] f_in,
    input  logic [SCORE_W-1:0] arr_max,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               err
);

    localparam int SW        = (PE_NUMBER > 1) ? $clog2(PE_NUMBER) : 1;
    localparam int TW        = $clog2(T_MAX + 1);
    localparam int TAW       = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int FLUSH_LEN = PE_NUMBER - 1 + ARR_LAT;
    localparam int PH_MAX    = (T_MAX > PE_NUMBER + ARR_LAT) ? T_MAX : PE_NUMBER + ARR_LAT;
    localparam int PW        = $clog2(PH_MAX + 1);

    state_e             r_state, w_state_next;
    logic [SW-1:0]      r_s_cnt, w_s_cnt_next;
    logic [TW-1:0]      r_t_cnt, w_t_cnt_next;
    logic [TW-1:0]      r_t_len, w_t_len_next;
    logic [PW-1:0]      r_phase, w_phase_next;
    logic               r_err, r_arr_rst, r_arr_valid, r_pe_enable, r_done;
    logic [SCORE_W-1:0] r_score;

    logic               w_acc, w_err_set, w_score_load;
    logic               w_s_we, w_t_we;
    logic [SW-1:0]      w_s_waddr;

    assign in_ready = !reset && (r_state == ST_IDLE || r_state == ST_LOAD_S
                                 || r_state == ST_LOAD_T);
    assign w_acc    = in_valid && in_ready;

    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_t_cnt_next = r_t_cnt;
        w_t_len_next = r_t_len;
        w_phase_next = r_phase;
        w_err_set    = 1'b0;
        w_score_load = 1'b0;
        w_s_we       = 1'b0;
        w_t_we       = 1'b0;
        w_s_waddr    = r_s_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (in_is_t) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_s_we    = 1'b1;
                        w_s_waddr = '0;
                        if (in_last) begin
                            if (PE_NUMBER == 1) begin
                                w_state_next = ST_LOAD_T;
                                w_t_cnt_next = '0;
                            end else begin
                                w_err_set = 1'b1;
                            end
                        end else begin
                            w_state_next = ST_LOAD_S;
                            w_s_cnt_next = SW'(1);
                        end
                    end
                end
            end
            ST_LOAD_S: begin
                if (w_acc) begin
                    if (in_is_t) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_s_we = 1'b1;
                        if (r_s_cnt == SW'(PE_NUMBER - 1)) begin
                            // Exactly PE_NUMBER symbols is the only legal query.
                            if (in_last) begin
                                w_state_next = ST_LOAD_T;
                                w_t_cnt_next = '0;
                            end else begin
                                w_err_set    = 1'b1;
                                w_state_next = ST_IDLE;
                            end
                        end else if (in_last) begin
                            w_err_set    = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_s_cnt_next = r_s_cnt + SW'(1);
                        end
                    end
                end
            end
            ST_LOAD_T: begin
                if (w_acc) begin
                    if (!in_is_t || r_t_cnt == TW'(T_MAX)) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_t_we = 1'b1;
                        if (in_last) begin
                            w_state_next = ST_ARST;
                            w_t_len_next = r_t_cnt + TW'(1);
                        end else begin
                            w_t_cnt_next = r_t_cnt + TW'(1);
                        end
                    end
                end
            end
            ST_ARST: begin
                w_state_next = ST_SEED;
                w_phase_next = '0;
            end
            ST_SEED: begin
                if (r_phase == PW'(PE_NUMBER - 1)) begin
                    w_state_next = ST_STREAM;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + PW'(1);
                end
            end
            ST_STREAM: begin
                if (r_phase + PW'(1) == PW'(r_t_len)) begin
                    w_state_next = ST_FLUSH;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + PW'(1);
                end
            end
            ST_FLUSH: begin
                if (r_phase == PW'(FLUSH_LEN - 1)) begin
                    // Last T symbol has now reached the last PE's max_out.
                    w_score_load = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_phase_next = r_phase + PW'(1);
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Array-facing controls are registered from the next state so they are
    // valid for the whole state cycle and settle before the array's falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_s_cnt     <= '0;
            r_t_cnt     <= '0;
            r_t_len     <= '0;
            r_phase     <= '0;
            r_err       <= 1'b0;
            r_score     <= '0;
            r_arr_rst   <= 1'b0;
            r_arr_valid <= 1'b0;
            r_pe_enable <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s_cnt     <= w_s_cnt_next;
            r_t_cnt     <= w_t_cnt_next;
            r_t_len     <= w_t_len_next;
            r_phase     <= w_phase_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_score_load) begin
                r_score <= arr_max;
            end
            r_arr_rst   <= (w_state_next == ST_ARST);
            r_arr_valid <= (w_state_next == ST_SEED) || (w_state_next == ST_STREAM)
                           || (w_state_next == ST_FLUSH);
            r_pe_enable <= (w_state_next == ST_STREAM) || (w_state_next == ST_FLUSH);
            r_done      <= (w_state_next == ST_DONE);
        end
    end

    // Read addresses come from the next phase value, so each symbol is fetched
    // one cycle ahead and lands on s_out/t_out in its own SEED/STREAM cycle.
    sym_buffer #(.DEPTH(PE_NUMBER)) u_s_buf (
        .clk       (clk),
        .srst      (reset),
        .i_wr_en   (w_s_we),
        .i_wr_addr (w_s_waddr),
        .i_wr_data (in_base),
        .i_rd_en   (w_state_next == ST_SEED),
        .i_rd_addr (SW'(w_phase_next)),
        .o_rd_data (s_out)
    );

    sym_buffer #(.DEPTH(T_MAX)) u_t_buf (
        .clk       (clk),
        .srst      (reset),
        .i_wr_en   (w_t_we),
        .i_wr_addr (TAW'(r_t_cnt)),
        .i_wr_data (in_base),
        .i_rd_en   (w_state_next == ST_STREAM),
        .i_rd_addr (TAW'(w_phase_next)),
        .o_rd_data (t_out)
    );

    assign arr_reset = reset | r_arr_rst;
    assign arr_valid = r_arr_valid;
    assign pe_enable = r_pe_enable;
    assign done      = r_done;
    assign score     = r_score;
    assign err       = r_err;
    assign max_in    = '0;
    assign v_in      = '0;
    assign f_in      = '0;

endmodule
